// File: rtl/tl_traffic_model.sv
// tl_traffic_model: behavioural traffic model for a two-road intersection.
// Four lanes (A straight, A left, B straight, B left), each holding a queue of
// cars counted up by arrivals and down by departures. A lane may only discharge
// when its light is "go", after one cycle of start-up lost time, and then at
// most once every DEPART_GAP cycles.
// Optional feature: define TL_MODEL_CONFLICT_CHK_EN to compile in the sticky
// conflict flag (both roads showing a non-red light on the same edge).
// There is no valid/ready handshake here: arrivals are one-cycle pulses that
// are always accepted (or counted as a drop when the lane queue is full).
module tl_traffic_model #(
  parameter int QW         = 4,
  parameter int DEPART_GAP = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arr_a,
  input  logic          arr_al,
  input  logic          arr_b,
  input  logic          arr_bl,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tal,
  output logic          Tb,
  output logic          Tbl,
  output logic [QW-1:0] q_a,
  output logic [QW-1:0] q_al,
  output logic [QW-1:0] q_b,
  output logic [QW-1:0] q_bl,
  output logic          drop,
  output logic          conflict,
  // Lane FSM states packed {bl, b, al, a}, two bits each (0 WAIT, 1 START, 2 FLOW)
  output logic [7:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_START = 2'd1,
    ST_FLOW  = 2'd2
  } lane_state_t;

  localparam logic [1:0]    LIGHT_GREEN = 2'b00;
  localparam logic [1:0]    LIGHT_LEFT  = 2'b10;
  localparam logic [1:0]    LIGHT_RED   = 2'b11;
  localparam logic [3:0]    GAP_RELOAD  = 4'(DEPART_GAP - 1);
  localparam logic [QW-1:0] Q_FULL      = {QW{1'b1}};

  // Lane index: 0 = A straight, 1 = A left, 2 = B straight, 3 = B left
  logic [3:0]    go;
  logic [3:0]    arr;
  logic [3:0]    depart;
  logic [3:0]    drop_ev;

  lane_state_t   state_q [4];
  lane_state_t   state_d [4];
  logic [3:0]    gap_q   [4];
  logic [3:0]    gap_d   [4];
  logic [QW-1:0] cnt_q   [4];
  logic [QW-1:0] cnt_d   [4];
  logic          drop_q;

  assign go  = {Lb == LIGHT_LEFT, Lb == LIGHT_GREEN, La == LIGHT_LEFT, La == LIGHT_GREEN};
  assign arr = {arr_bl, arr_b, arr_al, arr_a};

  // Lane FSMs: start-up lost time, then gap-paced departures while the light stays go
  always_comb begin
    depart = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      gap_d[i]   = gap_q[i];
      case (state_q[i])
        ST_WAIT: begin
          if (go[i]) state_d[i] = ST_START;
        end
        ST_START: begin
          if (go[i]) begin
            state_d[i] = ST_FLOW;
            gap_d[i]   = 4'd0;
          end else begin
            state_d[i] = ST_WAIT;
          end
        end
        ST_FLOW: begin
          if (go[i]) begin
            if (gap_q[i] == 4'd0 && cnt_q[i] != '0) begin
              depart[i] = 1'b1;
              gap_d[i]  = GAP_RELOAD;
            end else if (gap_q[i] != 4'd0) begin
              gap_d[i] = gap_q[i] - 4'd1;
            end
          end else begin
            state_d[i] = ST_WAIT;
          end
        end
        default: state_d[i] = ST_WAIT;
      endcase
    end
  end

  // Queue counts: arrival and departure in the same cycle cancel out
  always_comb begin
    drop_ev = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (arr[i] && !depart[i]) begin
        if (cnt_q[i] == Q_FULL) drop_ev[i] = 1'b1;
        else                    cnt_d[i]   = cnt_q[i] + 1'b1;
      end else if (!arr[i] && depart[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Lane state, gap counters, queue counts and sticky drop flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_WAIT;
        gap_q[i]   <= 4'd0;
        cnt_q[i]   <= '0;
      end
      drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        gap_q[i]   <= gap_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      drop_q <= drop_q | (|drop_ev);
    end
  end

`ifdef TL_MODEL_CONFLICT_CHK_EN
  logic conflict_q;

  // Sticky flag: both roads non-red on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) conflict_q <= 1'b0;
    else if (La != LIGHT_RED && Lb != LIGHT_RED) conflict_q <= 1'b1;
  end

  assign conflict = conflict_q;
`else
  assign conflict = 1'b0;
`endif

  assign q_a  = cnt_q[0];
  assign q_al = cnt_q[1];
  assign q_b  = cnt_q[2];
  assign q_bl = cnt_q[3];

  assign Ta  = |cnt_q[0];
  assign Tal = |cnt_q[1];
  assign Tb  = |cnt_q[2];
  assign Tbl = |cnt_q[3];

  assign drop = drop_q;

  assign dbg_state = {state_q[3], state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_tl_traffic_model.sv
// tb_tl_traffic_model: directed bench for tl_traffic_model (QW=4, DEPART_GAP=2).
// Each step drives one cycle of inputs, pushes the expected post-edge outputs
// onto exp_q, and pops/compares them #1 after the rising edge.
module tb_tl_traffic_model;

  localparam int QW = 4;
  localparam int DG = 2;
  localparam int OW = 4 * QW + 6;

  logic          clk;
  logic          reset_n;
  logic          arr_a, arr_al, arr_b, arr_bl;
  logic [1:0]    La, Lb;
  logic          Ta, Tal, Tb, Tbl;
  logic [QW-1:0] q_a, q_al, q_b, q_bl;
  logic          drop, conflict;
  logic [7:0]    dbg_state;

  logic [OW-1:0] exp_q[$];
  int            checks;
  int            errors;
  logic          conf_model;

  tl_traffic_model #(.QW(QW), .DEPART_GAP(DG)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .arr_a     (arr_a),
    .arr_al    (arr_al),
    .arr_b     (arr_b),
    .arr_bl    (arr_bl),
    .La        (La),
    .Lb        (Lb),
    .Ta        (Ta),
    .Tal       (Tal),
    .Tb        (Tb),
    .Tbl       (Tbl),
    .q_a       (q_a),
    .q_al      (q_al),
    .q_b       (q_b),
    .q_bl      (q_bl),
    .drop      (drop),
    .conflict  (conflict),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive at negedge, push expectation, compare after the edge.
  // arr is {bl, b, al, a}.
  task automatic step(input string tag, input logic rst_n, input logic [1:0] la,
                      input logic [1:0] lb, input logic [3:0] arr,
                      input int qa, input int qal, input int qb, input int qbl,
                      input logic drp);
    logic [OW-1:0] expv;
    logic [OW-1:0] obs;
    @(negedge clk);
    reset_n = rst_n;
    La      = la;
    Lb      = lb;
    {arr_bl, arr_b, arr_al, arr_a} = arr;
    if (!rst_n) conf_model = 1'b0;
`ifdef TL_MODEL_CONFLICT_CHK_EN
    else if (la != 2'b11 && lb != 2'b11) conf_model = 1'b1;
`endif
    expv = {QW'(qa), QW'(qal), QW'(qb), QW'(qbl),
            qa != 0, qal != 0, qb != 0, qbl != 0, drp, conf_model};
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    obs  = {q_a, q_al, q_b, q_bl, Ta, Tal, Tb, Tbl, drop, conflict};
    expv = exp_q.pop_front();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] got, input logic [1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    conf_model = 1'b0;
    reset_n    = 1'b0;
    La         = 2'b11;
    Lb         = 2'b11;
    {arr_bl, arr_b, arr_al, arr_a} = 4'b1111;

    // Reset with all arrivals high, then release
    step("reset0", 0, 2'b11, 2'b11, 4'b1111, 0, 0, 0, 0, 0);
    step("reset1", 0, 2'b11, 2'b11, 4'b1111, 0, 0, 0, 0, 0);
    step("release", 1, 2'b11, 2'b11, 4'b0000, 0, 0, 0, 0, 0);
    check_state("fsm_after_reset", dbg_state[1:0], 2'd0);

    // Arrivals under all-red: A straight x3, then B left x1
    for (int k = 1; k <= 3; k++)
      step("arr_a", 1, 2'b11, 2'b11, 4'b0001, k, 0, 0, 0, 0);
    step("arr_bl", 1, 2'b11, 2'b11, 4'b1000, 3, 0, 0, 1, 0);

    // A green: start-up lost time, then one departure every 2 cycles
    step("flow_a1", 1, 2'b00, 2'b11, 4'b0000, 3, 0, 0, 1, 0);
    step("flow_a2", 1, 2'b00, 2'b11, 4'b0000, 3, 0, 0, 1, 0);
    step("flow_a3", 1, 2'b00, 2'b11, 4'b0000, 2, 0, 0, 1, 0);
    step("flow_a4", 1, 2'b00, 2'b11, 4'b0000, 2, 0, 0, 1, 0);
    step("flow_a5", 1, 2'b00, 2'b11, 4'b0000, 1, 0, 0, 1, 0);
    step("flow_a6", 1, 2'b00, 2'b11, 4'b0000, 1, 0, 0, 1, 0);
    step("flow_a7", 1, 2'b00, 2'b11, 4'b0000, 0, 0, 0, 1, 0);
    step("flow_a8", 1, 2'b00, 2'b11, 4'b0000, 0, 0, 0, 1, 0);
    step("red_a", 1, 2'b11, 2'b11, 4'b0000, 0, 0, 0, 1, 0);

    // A left: two arrow cycles then yellow gives no departure
    step("arr_al1", 1, 2'b11, 2'b11, 4'b0010 >> 0 & 4'b0010, 0, 1, 0, 1, 0);
    step("arr_al2", 1, 2'b11, 2'b11, 4'b0010, 0, 2, 0, 1, 0);
    step("left1", 1, 2'b10, 2'b11, 4'b0000, 0, 2, 0, 1, 0);
    check_state("al_start", dbg_state[3:2], 2'd1);
    step("left2", 1, 2'b10, 2'b11, 4'b0000, 0, 2, 0, 1, 0);
    check_state("al_flow", dbg_state[3:2], 2'd2);
    step("left_yel", 1, 2'b01, 2'b11, 4'b0000, 0, 2, 0, 1, 0);
    check_state("al_wait", dbg_state[3:2], 2'd0);
    step("red_al", 1, 2'b11, 2'b11, 4'b0000, 0, 2, 0, 1, 0);

    // Fill B straight to capacity, then overflow
    for (int k = 1; k <= 15; k++)
      step("fill_b", 1, 2'b11, 2'b11, 4'b0100, 0, 2, k, 1, 0);
    step("drop_b", 1, 2'b11, 2'b11, 4'b0100, 0, 2, 15, 1, 1);

    // B green with arrivals held: count holds at full through departures
    for (int k = 0; k < 5; k++)
      step("full_flow_b", 1, 2'b11, 2'b00, 4'b0100, 0, 2, 15, 1, 1);
    step("drain_b1", 1, 2'b11, 2'b00, 4'b0000, 0, 2, 15, 1, 1);
    step("drain_b2", 1, 2'b11, 2'b00, 4'b0000, 0, 2, 14, 1, 1);
    step("drain_b3", 1, 2'b11, 2'b00, 4'b0000, 0, 2, 14, 1, 1);
    step("drain_b4", 1, 2'b11, 2'b00, 4'b0000, 0, 2, 13, 1, 1);

    // B left arrow: single car leaves on the third go edge, Tbl falls
    step("left_b1", 1, 2'b11, 2'b10, 4'b0000, 0, 2, 13, 1, 1);
    step("left_b2", 1, 2'b11, 2'b10, 4'b0000, 0, 2, 13, 1, 1);
    step("left_b3", 1, 2'b11, 2'b10, 4'b0000, 0, 2, 13, 0, 1);

    // Both roads non-red for one cycle, then A green alone (conflict sticky)
    step("conflict", 1, 2'b00, 2'b01, 4'b0000, 0, 2, 13, 0, 1);
    for (int k = 0; k < 3; k++)
      step("conflict_hold", 1, 2'b00, 2'b11, 4'b0000, 0, 2, 13, 0, 1);

    // Reset mid-operation with arrivals high clears everything
    step("mid_reset", 0, 2'b00, 2'b11, 4'b1111, 0, 0, 0, 0, 0);
    check_state("a_wait_after_reset", dbg_state[1:0], 2'd0);

    // After reset, A must pay start-up lost time again
    step("post_arr1", 1, 2'b11, 2'b11, 4'b0001, 1, 0, 0, 0, 0);
    step("post_arr2", 1, 2'b11, 2'b11, 4'b0001, 2, 0, 0, 0, 0);
    step("post_go1", 1, 2'b00, 2'b11, 4'b0000, 2, 0, 0, 0, 0);
    step("post_go2", 1, 2'b00, 2'b11, 4'b0000, 2, 0, 0, 0, 0);
    step("post_go3", 1, 2'b00, 2'b11, 4'b0000, 1, 0, 0, 0, 0);
    step("post_go4", 1, 2'b00, 2'b11, 4'b0000, 1, 0, 0, 0, 0);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_traffic_model.md
TL_TRAFFIC_MODEL -- requirements
Module: tl_traffic_model

Interface
REQ-001 Parameter QW, default 4: queue counter width per lane (capacity 2^QW-1).
REQ-002 Parameter DEPART_GAP, default 2, legal range 1..15: minimum cycles between successive departures from one lane.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 arr_a, arr_al, arr_b, arr_bl  input  1 each  one-car arrival per cycle high: A straight, A left, B straight, B left.
REQ-006 La, Lb  input  2 each  light codes from the controller: 00 green, 01 yellow, 10 left-arrow, 11 red.
REQ-007 Ta, Tal, Tb, Tbl  output  1 each  sensor lines to the controller: lane queue non-zero.
REQ-008 q_a, q_al, q_b, q_bl  output  QW each  current lane queue counts.
REQ-009 drop  output  1  sticky: an arrival was lost to a full queue.
REQ-010 conflict  output  1  sticky: illegal concurrent non-red lights (see Configuration).

Function
REQ-011 Lane "go" condition: A straight when La==00; A left when La==10; B straight when Lb==00; B left when Lb==10; yellow and red are never go.
REQ-012 Each lane runs an independent FSM: WAIT, START, FLOW.
REQ-013 WAIT -> START on a cycle with go; otherwise remain WAIT.
REQ-014 START -> FLOW on a cycle with go; START -> WAIT on no-go; no departure in START (start-up lost time).
REQ-015 FLOW remains FLOW while go; FLOW -> WAIT on no-go, with no departure that cycle.
REQ-016 Entering FLOW loads the lane gap counter with 0.
REQ-017 In FLOW with go: departure occurs when gap counter==0 and queue>0; gap counter then loads DEPART_GAP-1; otherwise gap counter decrements toward 0 (saturate at 0).
REQ-018 Consequently the first departure occurs on the third consecutive go-sampled edge; later departures every DEPART_GAP cycles.
REQ-019 Queue update per edge: arrival only -> +1; departure only -> -1; both -> unchanged; neither -> unchanged.
REQ-020 Queue full (2^QW-1) with arrival and no departure: count holds, drop set to 1.
REQ-021 Queue empty: no departure is possible; gap counter still behaves per REQ-017.
REQ-022 Ta/Tal/Tb/Tbl = (corresponding q != 0), combinational from registered counts; change in the same cycle as the count.
REQ-023 drop, once set, remains 1 until reset.

Reset
REQ-024 On reset_n==0 at a rising edge: all queues 0, all lane FSMs WAIT, gap counters 0, drop 0, conflict 0; hence all T* outputs 0.
REQ-025 Reset mid-operation discards queued cars and in-progress FLOW; arrivals and departures in the reset cycle are ignored.

Configuration
REQ-026 Macro TL_MODEL_CONFLICT_CHK_EN defined: conflict sets (sticky until reset) on any edge where La!=11 and Lb!=11 simultaneously.
REQ-027 Macro undefined: no conflict logic compiled; conflict is constant 0; all other behaviour identical.

Verification
REQ-028 Reset with arrivals high, then release -> all q=0, T*=0, drop=0, conflict=0 after first reset edge.
REQ-029 La=Lb=11, arr_a high 3 cycles -> q_a=3, Ta=1, no departures; arr_bl 1 cycle -> q_bl=1, Tbl=1.
REQ-030 q_a=3, DEPART_GAP=2, La=00 held -> q_a 3,3,2,2,1,1,0 on successive edges after go; Ta falls with q_a=0.
REQ-031 q_al=2, La=10 for 2 cycles then 01 -> no departure (WAIT->START->FLOW->WAIT), q_al stays 2.
REQ-032 QW=4, q_b=15, Lb=11, arr_b pulse -> q_b=15, drop=1; then Lb=00 with arr_b held -> count holds during departure cycles.
REQ-033 With TL_MODEL_CONFLICT_CHK_EN: La=00, Lb=01 one cycle -> conflict=1 and stays 1; without macro -> conflict=0.
